// File: rtl/gnpu_cop_pkg.sv
// gnpu_cop_pkg
//   Shared definitions for the gnpu coprocessor dispatch front end:
//   custom-1 opcode, funct3 encodings, the internal operation enum,
//   response status codes, the instruction-queue entry layout and the
//   instruction decoder.
package gnpu_cop_pkg;

    // Operand width carried in a queue entry; the dispatch REG_W must match.
    localparam int COP_REG_W = 32;

    localparam logic [6:0] COP_OPCODE    = 7'b0101011;

    localparam logic [2:0] F3_PRELOADC   = 3'b001;
    localparam logic [2:0] F3_TMMA       = 3'b010;
    localparam logic [2:0] F3_POSTSTOREC = 3'b011;
    localparam logic [2:0] F3_PRELOADA   = 3'b100;

    typedef enum logic [2:0] {
        OP_PLC,
        OP_PLA,
        OP_MMA,
        OP_STC,
        OP_ILL
    } cop_op_e;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_ILL = 2'd1;

    typedef struct packed {
        cop_op_e                op;
        logic [2:0]             funct3;
        logic [COP_REG_W-1:0]   rs1;
        logic [COP_REG_W-1:0]   rs2;
        logic [COP_REG_W-1:0]   rs3;
    } cop_entry_t;

    function automatic cop_op_e cop_decode(input logic [6:0] opcode,
                                           input logic [2:0] funct3);
        cop_op_e op;
        op = OP_ILL;
        if (opcode == COP_OPCODE) begin
            case (funct3)
                F3_PRELOADC:   op = OP_PLC;
                F3_PRELOADA:   op = OP_PLA;
                F3_TMMA:       op = OP_MMA;
                F3_POSTSTOREC: op = OP_STC;
                default:       op = OP_ILL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/gnpu_cop_fifo.sv
// gnpu_cop_fifo
//   Synchronous in-order queue of cop_entry_t. Head entry is presented
//   combinationally on rdata while the queue is not empty.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, wdata   write one entry (caller guarantees !full)
//     pop           drop the head entry (caller guarantees !empty)
//     rdata         head entry
//     empty, full   occupancy flags
//     count         current number of entries
import gnpu_cop_pkg::*;

module gnpu_cop_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  cop_entry_t      wdata,
    input  logic            pop,
    output cop_entry_t      rdata,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count
);

    cop_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage holds payload only, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/gnpu_cop_dispatch.sv
// gnpu_cop_dispatch
//   Front end of gnpu. Accepts custom-1 coprocessor instructions from the
//   CPU, queues them in order, issues each one to the load, MMA or store
//   unit while honouring load->tmma->poststorec ordering, and returns one
//   acknowledge word per instruction.
//   Ports:
//     clk, rst                         clock, asynchronous active-high reset
//     cpu_tpu_req_*                    CPU request channel (insn + 3 operands)
//     cpu_tpu_resp_*                   response channel {seq, funct3, status}
//     ld_/mma_/st_cmd_vld_o, _rdy_i    unit command handshakes
//     ld_cmd_is_c_o                    1 = preloadc, 0 = preloada
//     cmd_rs1_o..cmd_rs3_o             operands of the queue head
//     ld_/mma_/st_done_i               single-cycle completion pulses
//     idle_o                           nothing queued, pending or outstanding
//     err_o                            sticky: completion with nothing outstanding
import gnpu_cop_pkg::*;

module gnpu_cop_dispatch #(
    parameter int INST_W  = 32,
    parameter int REG_W   = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_tpu_req_vld_i,
    output logic              cpu_tpu_req_rdy_o,
    input  logic [INST_W-1:0] cpu_tpu_req_insn_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs1_data_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs2_data_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs3_data_i,
    output logic              cpu_tpu_resp_vld_o,
    input  logic              cpu_tpu_resp_rdy_i,
    output logic [REG_W-1:0]  cpu_tpu_resp_data_o,
    output logic              ld_cmd_vld_o,
    input  logic              ld_cmd_rdy_i,
    output logic              ld_cmd_is_c_o,
    output logic              mma_cmd_vld_o,
    input  logic              mma_cmd_rdy_i,
    output logic              st_cmd_vld_o,
    input  logic              st_cmd_rdy_i,
    output logic [REG_W-1:0]  cmd_rs1_o,
    output logic [REG_W-1:0]  cmd_rs2_o,
    output logic [REG_W-1:0]  cmd_rs3_o,
    input  logic              ld_done_i,
    input  logic              mma_done_i,
    input  logic              st_done_i,
    output logic              idle_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int QCW   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
        logic [CNT_W-1:0] n;
        n = c;
        if (inc && !dec)                 n = c + 1'b1;
        else if (dec && !inc && c != '0) n = c - 1'b1;
        return n;
    endfunction

    function automatic logic cnt_underflow(input logic [CNT_W-1:0] c,
                                           input logic inc,
                                           input logic dec);
        return dec && !inc && (c == '0);
    endfunction

    cop_entry_t        req_entry;
    cop_entry_t        head;
    logic              q_empty;
    logic              q_full;
    logic [QCW-1:0]    q_count;
    logic [QCW-1:0]    q_count_nxt;
    logic              push;
    logic              pop;
    logic              req_rdy_q;

    logic              resp_vld_q;
    logic [REG_W-1:0]  resp_data_q;
    logic [REG_W-1:0]  resp_word;
    logic [7:0]        seq_q;

    logic [CNT_W-1:0]  ld_cnt;
    logic [CNT_W-1:0]  mma_cnt;
    logic [CNT_W-1:0]  st_cnt;
    logic              err_q;

    logic              slot_free;
    logic              head_ok;
    logic              ld_vld;
    logic              mma_vld;
    logic              st_vld;
    logic              ill_retire;
    logic              ld_hs;
    logic              mma_hs;
    logic              st_hs;

    // Only opcode and funct3 participate in decode.
    logic              unused_insn_bits;
    assign unused_insn_bits = ^{cpu_tpu_req_insn_i[INST_W-1:15], cpu_tpu_req_insn_i[11:7], q_full};

    always_comb begin
        req_entry        = '0;
        req_entry.op     = cop_decode(cpu_tpu_req_insn_i[6:0], cpu_tpu_req_insn_i[14:12]);
        req_entry.funct3 = cpu_tpu_req_insn_i[14:12];
        req_entry.rs1    = cpu_tpu_req_rs1_data_i;
        req_entry.rs2    = cpu_tpu_req_rs2_data_i;
        req_entry.rs3    = cpu_tpu_req_rs3_data_i;
    end

    assign push = cpu_tpu_req_vld_i && req_rdy_q;

    gnpu_cop_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (req_entry),
        .pop   (pop),
        .rdata (head),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    // Issue. Every condition that gates a command can only become more
    // permissive while the head waits, so an asserted vld holds until rdy.
    always_comb begin
        slot_free  = !resp_vld_q || cpu_tpu_resp_rdy_i;
        head_ok    = !q_empty && slot_free;
        ld_vld     = head_ok && (head.op == OP_PLC || head.op == OP_PLA) && (ld_cnt < MAX_CNT);
        mma_vld    = head_ok && (head.op == OP_MMA) && (ld_cnt == '0) && (mma_cnt < MAX_CNT);
        st_vld     = head_ok && (head.op == OP_STC) && (mma_cnt == '0) && (st_cnt < MAX_CNT);
        ill_retire = head_ok && (head.op == OP_ILL);
        ld_hs      = ld_vld && ld_cmd_rdy_i;
        mma_hs     = mma_vld && mma_cmd_rdy_i;
        st_hs      = st_vld && st_cmd_rdy_i;
        pop        = ld_hs || mma_hs || st_hs || ill_retire;
    end

    always_comb begin
        resp_word        = '0;
        resp_word[1:0]   = (head.op == OP_ILL) ? ST_ILL : ST_OK;
        resp_word[4:2]   = head.funct3;
        resp_word[15:8]  = seq_q;
    end

    // Ready is registered: it reflects the occupancy after this edge.
    assign q_count_nxt = q_count + QCW'(push) - QCW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_rdy_q <= 1'b0;
        end else begin
            req_rdy_q <= (q_count_nxt != QCW'(DEPTH));
        end
    end

    // Response slot: loaded on retire, which already requires it to be free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            seq_q       <= '0;
        end else if (pop) begin
            resp_vld_q  <= 1'b1;
            resp_data_q <= resp_word;
            seq_q       <= seq_q + 1'b1;
        end else if (resp_vld_q && cpu_tpu_resp_rdy_i) begin
            resp_vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt  <= '0;
            mma_cnt <= '0;
            st_cnt  <= '0;
            err_q   <= 1'b0;
        end else begin
            ld_cnt  <= cnt_upd(ld_cnt,  ld_hs,  ld_done_i);
            mma_cnt <= cnt_upd(mma_cnt, mma_hs, mma_done_i);
            st_cnt  <= cnt_upd(st_cnt,  st_hs,  st_done_i);
            if (cnt_underflow(ld_cnt,  ld_hs,  ld_done_i)  ||
                cnt_underflow(mma_cnt, mma_hs, mma_done_i) ||
                cnt_underflow(st_cnt,  st_hs,  st_done_i)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cpu_tpu_req_rdy_o   = req_rdy_q;
    assign cpu_tpu_resp_vld_o  = resp_vld_q;
    assign cpu_tpu_resp_data_o = resp_data_q;
    assign ld_cmd_vld_o        = ld_vld;
    assign mma_cmd_vld_o       = mma_vld;
    assign st_cmd_vld_o        = st_vld;
    assign ld_cmd_is_c_o       = !q_empty && (head.op == OP_PLC);
    assign cmd_rs1_o           = q_empty ? '0 : head.rs1;
    assign cmd_rs2_o           = q_empty ? '0 : head.rs2;
    assign cmd_rs3_o           = q_empty ? '0 : head.rs3;
    assign idle_o              = q_empty && !resp_vld_q &&
                                 (ld_cnt == '0) && (mma_cnt == '0) && (st_cnt == '0);
    assign err_o               = err_q;

endmodule

// File: doc/gnpu_cop_dispatch.md
Name: gnpu_cop_dispatch

Overview:
- Front-end stage of gnpu; directly consumes the CPU coprocessor request channel (cpu_tpu_req_*) and drives the cpu_tpu_resp_* channel.
- Decodes custom-1 coprocessor instructions (opcode 7'b0101011) and buffers them in an in-order queue.
- Issues each instruction to the load, MMA or store unit, enforcing load→tmma→poststorec ordering hazards.
- Returns one acknowledge response per accepted instruction.

Parameters:
- INST_W, 32, instruction width (matches `COP_INST_WIDTH).
- REG_W, 32, operand/response width (matches `COP_REG_WIDTH); must be ≥16.
- DEPTH, 4, instruction queue entries; power of two, ≥2.
- MAX_OUT, 3, maximum outstanding commands per unit.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- cpu_tpu_req_vld_i  in  1  request valid.
- cpu_tpu_req_rdy_o  out  1  request ready.
- cpu_tpu_req_insn_i  in  INST_W  instruction.
- cpu_tpu_req_rs1_data_i / cpu_tpu_req_rs2_data_i / cpu_tpu_req_rs3_data_i  in  REG_W each  operands.
- cpu_tpu_resp_vld_o  out  1  response valid.
- cpu_tpu_resp_rdy_i  in  1  response ready.
- cpu_tpu_resp_data_o  out  REG_W  response word.
- ld_cmd_vld_o / ld_cmd_rdy_i  out / in  1 each  load-unit command handshake.
- ld_cmd_is_c_o  out  1  1 = preloadc, 0 = preloada.
- mma_cmd_vld_o / mma_cmd_rdy_i  out / in  1 each  MMA-unit command handshake.
- st_cmd_vld_o / st_cmd_rdy_i  out / in  1 each  store-unit command handshake.
- cmd_rs1_o / cmd_rs2_o / cmd_rs3_o  out  REG_W each  operands of the queue head; shared by all unit channels.
- ld_done_i / mma_done_i / st_done_i  in  1 each  single-cycle completion pulses.
- idle_o  out  1  queue empty and all outstanding counters zero.
- err_o  out  1  sticky: done pulse received while the matching counter is 0.

Behaviour:
- Reset (async, rst=1): queue emptied, counters 0, seq 0, resp register empty, err_o 0.
  - All vld outputs 0, req_rdy_o 0, data outputs 0, idle_o 1.
  - Done pulses during reset are ignored; any in-flight state is dropped.
- Decode:
  - Legal only if insn[6:0]==7'b0101011 and funct3=insn[14:12] ∈ {001 PRELOADC, 100 PRELOADA, 010 TMMA, 011 POSTSTOREC}.
  - Anything else decodes as ILL.
- Enqueue:
  - req_rdy_o = !full, registered; deasserted in the cycle the queue becomes full.
  - A handshake (vld&&rdy) writes {op, rs1, rs2, rs3}.
  - ILL instructions are enqueued too, so responses stay in order.
  - Enqueue and dequeue in the same cycle while full is not allowed (rdy already low). Same-cycle enqueue and dequeue at any other occupancy is allowed.
  - Pointers wrap modulo DEPTH.
- Issue from the head, at most one per cycle, strictly in order:
  - PRELOADx: ld_cmd_vld_o when ld_cnt<MAX_OUT.
  - TMMA: mma_cmd_vld_o when ld_cnt==0 and mma_cnt<MAX_OUT. All loads must be done first.
  - POSTSTOREC: st_cmd_vld_o when mma_cnt==0 and st_cnt<MAX_OUT.
  - ILL: retires with no unit command.
  - Every issue also requires the response slot to be free: slot empty, or draining this cycle (resp_vld&&resp_rdy).
  - Once a cmd vld is asserted it holds, with stable operands, until its rdy is seen.
- Retire:
  - On a unit handshake, or on an ILL retire, the head is popped and the response register is loaded the same cycle.
  - Response is visible the next cycle; minimum latency from req handshake to resp_vld is 2 cycles.
- Response word:
  - bits[1:0] status: 0 = OK, 1 = ILLEGAL.
  - bits[4:2] funct3.
  - bits[15:8] 8-bit sequence number; starts at 0, increments per response, wraps 255→0.
  - Upper bits are 0.
  - resp_vld_o holds until resp_rdy_i.
- Outstanding counters (ld/mma/st), width $clog2(MAX_OUT+1):
  - +1 on the unit handshake, −1 on done.
  - Both in the same cycle: unchanged.
  - Done at 0: counter stays 0 and err_o is set; err_o clears only on reset.
- idle_o is combinational: queue empty, resp slot empty, and all counters 0.

Decomposition:
- Package gnpu_cop_pkg holds:
  - COP_OPCODE = 7'b0101011.
  - funct3 constants F3_PRELOADC, F3_TMMA, F3_POSTSTOREC, F3_PRELOADA.
  - typedef enum cop_op_e {OP_PLC, OP_PLA, OP_MMA, OP_STC, OP_ILL}.
  - Status codes ST_OK = 0, ST_ILL = 1.
  - Queue-entry struct cop_entry_t.
- One sub-module: gnpu_cop_fifo (parameterised sync FIFO of cop_entry_t; full/empty outputs, async active-high reset).
- Decode, issue and counters stay in the top module.

Test Plan:
- Reset mid-operation: 3 instructions queued, rst pulsed → all vld outputs 0 immediately, idle_o 1; no stale response appears after release.
- Single PRELOADC (funct3 001), rs1=0x11, rs2=0x22, rs3=0x33, unit rdy=1 → ld_cmd_vld_o with is_c=1 and those operands; response 0x00000004 two cycles after the req handshake.
- PRELOADA, TMMA back-to-back, ld_done delayed 20 cycles → mma_cmd_vld_o stays 0 until the cycle after ld_done; responses carry seq 0 and 1 in order.
- Illegal insn (opcode 0x0B) → no unit command; response status 1 with funct3 field passed through; the following legal instruction still issues.
- Backpressure: resp_rdy_i=0, 6 requests, DEPTH=4 → req_rdy_o drops after 4 queued plus 1 in the resp slot; 256+ responses later, seq wraps 0xFF→0x00.
- ld_done_i pulsed with ld_cnt=0 → err_o=1 and stays set; ld_cnt remains 0.
